// File: rtl/fp_format_pkg.sv
// Shared definitions for the exception-tagged internal floating-point format.
//
// Packed word layout (size bits total):
//   [size-1 : size-2]  exception tag (zero / normal_number / infinity / NaN)
//   [sign_pos]         sign
//   [exp_msb:exp_lsb]  biased exponent
//   [man_msb:0]        mantissa fraction (hidden 1 not stored)
//
// Also holds the converter state encoding so that the FP blocks share one
// definition of IDLE/NORM/ROUND/DONE.
package fp_format_pkg;

  localparam int size_int             = 32;
  localparam int size_mantissa        = 24;
  localparam int size_exponent        = 8;
  localparam int size_exception_field = 2;
  localparam int size_counter         = 6;
  localparam int size                 = size_mantissa + size_exponent + size_exception_field;

  localparam int bias = 127;

  localparam logic [size_exception_field-1:0] zero          = 2'd0;
  localparam logic [size_exception_field-1:0] normal_number = 2'd1;
  localparam logic [size_exception_field-1:0] infinity      = 2'd2;
  localparam logic [size_exception_field-1:0] NaN           = 2'd3;

  // Bit positions inside the packed word.
  localparam int exc_msb  = size - 1;
  localparam int exc_lsb  = size - size_exception_field;
  localparam int sign_pos = size_mantissa + size_exponent - 1;
  localparam int exp_msb  = sign_pos - 1;
  localparam int exp_lsb  = size_mantissa - 1;
  localparam int man_msb  = size_mantissa - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  // Assemble a packed word; the mantissa argument carries the hidden bit,
  // which is dropped here.
  function automatic logic [size-1:0] pack_fp(
    input logic [size_exception_field-1:0] exc,
    input logic                            sign,
    input logic [size_exponent-1:0]        exponent,
    input logic [size_mantissa-1:0]        mantissa
  );
    pack_fp = {exc, sign, exponent, mantissa[size_mantissa-2:0]};
  endfunction

endpackage

// File: rtl/fp_round_nearest_even.sv
// Combinational round-to-nearest-even stage.
//
// Ports:
//   mantissa          normalised mantissa including hidden bit (1.M)
//   guard             first bit below the mantissa LSB
//   sticky            OR of all bits below the guard bit
//   exponent          biased exponent of the unrounded value
//   rounded_mantissa  mantissa after rounding (renormalised on carry-out)
//   rounded_exponent  exponent, incremented when rounding carried out
//   inexact           any discarded bit was nonzero
module fp_round_nearest_even
  import fp_format_pkg::*;
(
  input  logic [size_mantissa-1:0] mantissa,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic [size_exponent-1:0] exponent,
  output logic [size_mantissa-1:0] rounded_mantissa,
  output logic [size_exponent-1:0] rounded_exponent,
  output logic                     inexact
);

  logic                   round_up;
  logic [size_mantissa:0] sum;

  // Ties (guard set, sticky clear) only round up when the LSB is odd.
  assign round_up = guard & (sticky | mantissa[0]);
  assign sum      = {1'b0, mantissa} + {{size_mantissa{1'b0}}, round_up};
  assign inexact  = guard | sticky;

  // A carry out of the mantissa means it was all ones: the value becomes
  // 1.000... with the exponent bumped by one.
  always_comb begin
    rounded_mantissa = sum[size_mantissa-1:0];
    rounded_exponent = exponent;
    if (sum[size_mantissa]) begin
      rounded_mantissa = {1'b1, {(size_mantissa-1){1'b0}}};
      rounded_exponent = exponent + 1'b1;
    end
  end

endmodule

// File: rtl/int_to_fp_converter.sv
// Iterative integer to exception-tagged floating-point converter.
// Captures a signed/unsigned integer, normalises one bit per cycle, rounds
// to nearest-even and holds the result until the consumer takes it.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid_i/in_ready_o input handshake (ready only in IDLE)
//   int_i, is_signed_i   operand and its signedness
//   out_valid_o/out_ready_i output handshake
//   resulted_number_o    {exception, sign, exponent, fraction}
//   inexact_o            rounding discarded nonzero bits
module int_to_fp_converter
  import fp_format_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [size_int-1:0] int_i,
  input  logic                is_signed_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [size-1:0]     resulted_number_o,
  output logic                inexact_o
);

  localparam int guard_pos = size_int - size_mantissa - 1;
  localparam logic [size_exponent-1:0] exp_top = size_exponent'(bias + size_int - 1);

  conv_state_t             state;
  logic [size_int-1:0]     mag;
  logic [size_counter-1:0] cnt;
  logic                    sign_r;
  logic [size-1:0]         result_r;
  logic                    inexact_r;

  logic                     capture_sign;
  logic [size_int-1:0]      capture_mag;
  logic [size_exponent-1:0] exp_norm;
  logic [size_mantissa-1:0] mant_rnd;
  logic [size_exponent-1:0] exp_rnd;
  logic                     inexact_rnd;

  assign capture_sign = is_signed_i & int_i[size_int-1];
  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude.
  assign capture_mag  = capture_sign ? (~int_i + 1'b1) : int_i;

  // The counter holds the number of leading zeros shifted out.
  assign exp_norm = exp_top - size_exponent'(cnt);

  fp_round_nearest_even u_round (
    .mantissa         (mag[size_int-1 -: size_mantissa]),
    .guard            (mag[guard_pos]),
    .sticky           (|mag[guard_pos-1:0]),
    .exponent         (exp_norm),
    .rounded_mantissa (mant_rnd),
    .rounded_exponent (exp_rnd),
    .inexact          (inexact_rnd)
  );

  assign in_ready_o        = (state == IDLE);
  assign out_valid_o       = (state == DONE);
  assign resulted_number_o = result_r;
  assign inexact_o         = inexact_r;

  // Main control and datapath. A zero magnitude is recognised on the first
  // NORM cycle, which also keeps the shift loop from running forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sign_r    <= 1'b0;
      result_r  <= '0;
      inexact_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            sign_r <= capture_sign;
            mag    <= capture_mag;
            cnt    <= '0;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mag == '0) begin
            result_r  <= pack_fp(zero, 1'b0, '0, '0);
            inexact_r <= 1'b0;
            state     <= DONE;
          end else if (!mag[size_int-1]) begin
            mag <= {mag[size_int-2:0], 1'b0};
            cnt <= cnt + 1'b1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          result_r  <= pack_fp(normal_number, sign_r, exp_rnd, mant_rnd);
          inexact_r <= inexact_rnd;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
